// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared widths and level constants for the register-file
// writeback arbiter and its pending-write scoreboard.
package regfile_wb_arbiter_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int DATA_W     = 32;
  localparam int NUM_REGS   = 32;

  localparam logic RST_ENABLE = 1'b1;
  localparam logic VALID      = 1'b1;

endpackage

// File: rtl/regfile_wb_arbiter_wb_scoreboard.sv
// Pending-write scoreboard for multi-cycle destinations:
// set on issue, clear on writeback grant, set wins.
module wb_scoreboard
  import regfile_wb_arbiter_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  set_en,
  input  logic [REG_ADDR_W-1:0] set_addr,
  input  logic                  clr_en,
  input  logic [REG_ADDR_W-1:0] clr_addr,
  input  logic [REG_ADDR_W-1:0] rd_a_addr,
  input  logic [REG_ADDR_W-1:0] rd_b_addr,
  output logic                  rd_a_busy,
  output logic                  rd_b_busy,
  output logic [NUM_REGS-1:0]   busy_vec,
  output logic                  conflict
);

  logic [NUM_REGS-1:0] busy_q;
  logic [NUM_REGS-1:0] busy_d;
  logic                set_ok;
  logic                clr_same;
  logic                conflict_d;

  assign set_ok   = set_en && (set_addr != '0);
  assign clr_same = clr_en && (clr_addr == set_addr);

  always_comb begin
    busy_d = busy_q;
    if (clr_en)
      busy_d[clr_addr] = 1'b0;
    if (set_ok)
      busy_d[set_addr] = 1'b1;
    busy_d[0] = 1'b0;
  end

  // Re-issue to a register whose write is still outstanding
  assign conflict_d = set_ok && busy_q[set_addr] && !clr_same;

  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE) begin
      busy_q   <= '0;
      conflict <= 1'b0;
    end else begin
      busy_q   <= busy_d;
      conflict <= conflict_d;
    end
  end

  assign busy_vec  = busy_q;
  assign rd_a_busy = busy_q[rd_a_addr];
  assign rd_b_busy = busy_q[rd_b_addr];

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Arbitrates the single register-file write port between EX
// and a multi-cycle unit, with MC anti-starvation.
module regfile_wb_arbiter
  import regfile_wb_arbiter_pkg::*;
#(
  parameter int STARVE_LIMIT = 4,
  parameter int CNT_W        = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ex_wr_valid,
  input  logic [REG_ADDR_W-1:0] ex_wr_addr,
  input  logic [DATA_W-1:0]     ex_wr_data,
  output logic                  ex_stall,
  input  logic                  mc_issue,
  input  logic [REG_ADDR_W-1:0] mc_issue_addr,
  input  logic                  mc_wr_valid,
  input  logic [REG_ADDR_W-1:0] mc_wr_addr,
  input  logic [DATA_W-1:0]     mc_wr_data,
  output logic                  mc_wr_ready,
  output logic                  rf_write,
  output logic [REG_ADDR_W-1:0] rf_write_addr,
  output logic [DATA_W-1:0]     rf_write_data,
  input  logic [REG_ADDR_W-1:0] rd_a_addr,
  input  logic [REG_ADDR_W-1:0] rd_b_addr,
  output logic                  rd_a_busy,
  output logic                  rd_b_busy,
  output logic [NUM_REGS-1:0]   busy_vec,
  output logic                  mc_issue_conflict
);

  logic [CNT_W-1:0]      starve_cnt;
  logic                  at_limit;
  logic                  grant_mc;
  logic                  grant_ex;
  logic [REG_ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0]     wr_data;

  assign at_limit = (starve_cnt == CNT_W'(STARVE_LIMIT));

  // Both grants are forced low while reset is asserted
  assign grant_mc = (rst != RST_ENABLE) && (mc_wr_valid == VALID)
                    && (!ex_wr_valid || at_limit);
  assign grant_ex = (rst != RST_ENABLE) && (ex_wr_valid == VALID)
                    && !grant_mc;

  assign mc_wr_ready = grant_mc;
  assign ex_stall    = (rst != RST_ENABLE) && ex_wr_valid && grant_mc;

  assign wr_addr = grant_mc ? mc_wr_addr : ex_wr_addr;
  assign wr_data = grant_mc ? mc_wr_data : ex_wr_data;

  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE) begin
      starve_cnt <= '0;
    end else if (grant_mc || !mc_wr_valid) begin
      starve_cnt <= '0;
    end else if (!at_limit) begin
      starve_cnt <= starve_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE) begin
      rf_write      <= 1'b0;
      rf_write_addr <= '0;
      rf_write_data <= '0;
    end else if (grant_mc || grant_ex) begin
      rf_write      <= (wr_addr != '0);
      rf_write_addr <= wr_addr;
      rf_write_data <= wr_data;
    end else begin
      rf_write      <= 1'b0;
    end
  end

  wb_scoreboard u_sb (
    .clk       (clk),
    .rst       (rst),
    .set_en    (mc_issue),
    .set_addr  (mc_issue_addr),
    .clr_en    (grant_mc),
    .clr_addr  (mc_wr_addr),
    .rd_a_addr (rd_a_addr),
    .rd_b_addr (rd_b_addr),
    .rd_a_busy (rd_a_busy),
    .rd_b_busy (rd_b_busy),
    .busy_vec  (busy_vec),
    .conflict  (mc_issue_conflict)
  );

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench for regfile_wb_arbiter: expected writes
// are queued at stimulus time and matched on rf_write.
module tb_regfile_wb_arbiter;

  typedef struct packed {
    logic [4:0]  addr;
    logic [31:0] data;
  } wr_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        ex_wr_valid;
  logic [4:0]  ex_wr_addr;
  logic [31:0] ex_wr_data;
  logic        ex_stall;
  logic        mc_issue;
  logic [4:0]  mc_issue_addr;
  logic        mc_wr_valid;
  logic [4:0]  mc_wr_addr;
  logic [31:0] mc_wr_data;
  logic        mc_wr_ready;
  logic        rf_write;
  logic [4:0]  rf_write_addr;
  logic [31:0] rf_write_data;
  logic [4:0]  rd_a_addr;
  logic [4:0]  rd_b_addr;
  logic        rd_a_busy;
  logic        rd_b_busy;
  logic [31:0] busy_vec;
  logic        mc_issue_conflict;

  int n_checks = 0;
  int n_fail   = 0;
  wr_t exp_q[$];

  always #5 clk = ~clk;

  regfile_wb_arbiter #(.STARVE_LIMIT(4), .CNT_W(3)) dut (
    .clk               (clk),
    .rst               (rst),
    .ex_wr_valid       (ex_wr_valid),
    .ex_wr_addr        (ex_wr_addr),
    .ex_wr_data        (ex_wr_data),
    .ex_stall          (ex_stall),
    .mc_issue          (mc_issue),
    .mc_issue_addr     (mc_issue_addr),
    .mc_wr_valid       (mc_wr_valid),
    .mc_wr_addr        (mc_wr_addr),
    .mc_wr_data        (mc_wr_data),
    .mc_wr_ready       (mc_wr_ready),
    .rf_write          (rf_write),
    .rf_write_addr     (rf_write_addr),
    .rf_write_data     (rf_write_data),
    .rd_a_addr         (rd_a_addr),
    .rd_b_addr         (rd_b_addr),
    .rd_a_busy         (rd_a_busy),
    .rd_b_busy         (rd_b_busy),
    .busy_vec          (busy_vec),
    .mc_issue_conflict (mc_issue_conflict)
  );

  // Write monitor: every rf_write must match the oldest queued write
  always @(posedge clk) begin
    #2;
    if (rf_write === 1'b1) begin
      wr_t got;
      wr_t exp;
      got.addr = rf_write_addr;
      got.data = rf_write_data;
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_write: got addr=%0d data=%h, none expected",
                 got.addr, got.data);
      end else begin
        exp = exp_q.pop_front();
        if (got !== exp) begin
          n_fail++;
          $display("FAIL write_match: got addr=%0d data=%h, expected addr=%0d data=%h",
                   got.addr, got.data, exp.addr, exp.data);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    ex_wr_valid   = 1'b0;
    ex_wr_addr    = '0;
    ex_wr_data    = '0;
    mc_issue      = 1'b0;
    mc_issue_addr = '0;
    mc_wr_valid   = 1'b0;
    mc_wr_addr    = '0;
    mc_wr_data    = '0;
  endtask

  task automatic push(input logic [4:0] a, input logic [31:0] d);
    wr_t w;
    w.addr = a;
    w.data = d;
    exp_q.push_back(w);
  endtask

  task automatic check_hs(input string nm, input logic rdy, input logic stl);
    n_checks++;
    if (mc_wr_ready !== rdy || ex_stall !== stl) begin
      n_fail++;
      $display("FAIL %s: got ready=%b stall=%b, expected ready=%b stall=%b",
               nm, mc_wr_ready, ex_stall, rdy, stl);
    end
  endtask

  task automatic check_drained(input string nm);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL %s: %0d expected writes never seen", nm, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_reset();
    idle();
    rd_a_addr = '0;
    rd_b_addr = '0;
    rst = 1'b1;
    tick();
    tick();
    ex_wr_valid = 1'b1;
    ex_wr_addr  = 5'd3;
    mc_wr_valid = 1'b1;
    mc_wr_addr  = 5'd4;
    #1;
    check_hs("reset_handshake", 1'b0, 1'b0);
    tick();
    n_checks++;
    if (rf_write !== 1'b0 || rf_write_addr !== 5'd0 || rf_write_data !== 32'd0
        || busy_vec !== 32'd0 || mc_issue_conflict !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state: got we=%b a=%0d d=%h busy=%h cf=%b, expected all 0",
               rf_write, rf_write_addr, rf_write_data, busy_vec, mc_issue_conflict);
    end
    idle();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_ex_only();
    ex_wr_valid = 1'b1;
    ex_wr_addr  = 5'd10;
    ex_wr_data  = 32'hFFFF0000;
    #1;
    check_hs("ex_only_hs", 1'b0, 1'b0);
    push(5'd10, 32'hFFFF0000);
    tick();
    idle();
    tick();
    check_drained("ex_only_drain");
  endtask

  task automatic test_starvation();
    mc_wr_valid = 1'b1;
    mc_wr_addr  = 5'd3;
    mc_wr_data  = 32'hA5A5A5A5;
    ex_wr_valid = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      ex_wr_addr = 5'(i + 10);
      ex_wr_data = 32'h100 + 32'(i);
      #1;
      check_hs($sformatf("starve_wait%0d", i), 1'b0, 1'b0);
      push(5'(i + 10), 32'h100 + 32'(i));
      tick();
    end
    ex_wr_addr = 5'd20;
    ex_wr_data = 32'h200;
    #1;
    check_hs("starve_preempt", 1'b1, 1'b1);
    push(5'd3, 32'hA5A5A5A5);
    tick();
    mc_wr_valid = 1'b0;
    #1;
    check_hs("ex_resume", 1'b0, 1'b0);
    push(5'd20, 32'h200);
    tick();
    mc_wr_valid = 1'b1;
    ex_wr_addr  = 5'd21;
    ex_wr_data  = 32'h201;
    #1;
    check_hs("counter_cleared", 1'b0, 1'b0);
    push(5'd21, 32'h201);
    tick();
    idle();
    tick();
    check_drained("starve_drain");
  endtask

  task automatic test_scoreboard();
    mc_issue      = 1'b1;
    mc_issue_addr = 5'd8;
    tick();
    mc_issue  = 1'b0;
    rd_a_addr = 5'd8;
    rd_b_addr = 5'd7;
    #1;
    n_checks++;
    if (busy_vec !== 32'h100 || rd_a_busy !== 1'b1 || rd_b_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL sb_set: got busy=%h a=%b b=%b, expected busy=00000100 a=1 b=0",
               busy_vec, rd_a_busy, rd_b_busy);
    end
    mc_wr_valid = 1'b1;
    mc_wr_addr  = 5'd8;
    mc_wr_data  = 32'hFFFFFFFF;
    #1;
    check_hs("sb_mc_hs", 1'b1, 1'b0);
    push(5'd8, 32'hFFFFFFFF);
    tick();
    idle();
    n_checks++;
    if (busy_vec !== 32'h0 || rd_a_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL sb_clear: got busy=%h a=%b, expected busy=00000000 a=0",
               busy_vec, rd_a_busy);
    end
    tick();
    check_drained("sb_drain");
  endtask

  task automatic test_set_clear_conflict();
    mc_issue      = 1'b1;
    mc_issue_addr = 5'd8;
    tick();
    mc_wr_valid = 1'b1;
    mc_wr_addr  = 5'd8;
    mc_wr_data  = 32'h00001234;
    push(5'd8, 32'h00001234);
    tick();
    idle();
    n_checks++;
    if (busy_vec[8] !== 1'b1 || mc_issue_conflict !== 1'b0) begin
      n_fail++;
      $display("FAIL set_wins: got busy8=%b cf=%b, expected busy8=1 cf=0",
               busy_vec[8], mc_issue_conflict);
    end
    mc_issue      = 1'b1;
    mc_issue_addr = 5'd9;
    tick();
    n_checks++;
    if (mc_issue_conflict !== 1'b0) begin
      n_fail++;
      $display("FAIL first_issue: got cf=%b, expected 0", mc_issue_conflict);
    end
    tick();
    mc_issue = 1'b0;
    n_checks++;
    if (mc_issue_conflict !== 1'b1 || busy_vec !== 32'h300) begin
      n_fail++;
      $display("FAIL conflict_pulse: got cf=%b busy=%h, expected cf=1 busy=00000300",
               mc_issue_conflict, busy_vec);
    end
    tick();
    n_checks++;
    if (mc_issue_conflict !== 1'b0) begin
      n_fail++;
      $display("FAIL conflict_single: got cf=%b, expected 0", mc_issue_conflict);
    end
    check_drained("conflict_drain");
  endtask

  task automatic test_r0();
    ex_wr_valid = 1'b1;
    ex_wr_addr  = 5'd0;
    ex_wr_data  = 32'hDEADBEEF;
    mc_issue      = 1'b1;
    mc_issue_addr = 5'd0;
    rd_a_addr = 5'd0;
    #1;
    check_hs("r0_ex_hs", 1'b0, 1'b0);
    tick();
    idle();
    n_checks++;
    if (rf_write !== 1'b0 || busy_vec !== 32'h300 || rd_a_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL r0_ex: got we=%b busy=%h a=%b, expected we=0 busy=00000300 a=0",
               rf_write, busy_vec, rd_a_busy);
    end
    mc_wr_valid = 1'b1;
    mc_wr_addr  = 5'd0;
    mc_wr_data  = 32'h12345678;
    #1;
    check_hs("r0_mc_hs", 1'b1, 1'b0);
    tick();
    idle();
    n_checks++;
    if (rf_write !== 1'b0) begin
      n_fail++;
      $display("FAIL r0_mc: got we=%b, expected 0", rf_write);
    end
    tick();
    check_drained("r0_drain");
  endtask

  task automatic test_reset_mid();
    mc_wr_valid = 1'b1;
    mc_wr_addr  = 5'd20;
    mc_wr_data  = 32'hCAFE0020;
    ex_wr_valid = 1'b1;
    ex_wr_addr  = 5'd21;
    ex_wr_data  = 32'hCAFE0021;
    for (int i = 0; i < 4; i++) begin
      push(5'd21, 32'hCAFE0021);
      tick();
    end
    rst = 1'b1;
    #1;
    check_hs("rst_mid_hs", 1'b0, 1'b0);
    tick();
    rst = 1'b0;
    n_checks++;
    if (rf_write !== 1'b0 || rf_write_addr !== 5'd0 || rf_write_data !== 32'd0
        || busy_vec !== 32'd0 || mc_issue_conflict !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_mid_state: got we=%b a=%0d d=%h busy=%h cf=%b, expected all 0",
               rf_write, rf_write_addr, rf_write_data, busy_vec, mc_issue_conflict);
    end
    for (int i = 1; i <= 4; i++) begin
      #1;
      check_hs($sformatf("rst_cnt_wait%0d", i), 1'b0, 1'b0);
      push(5'd21, 32'hCAFE0021);
      tick();
    end
    #1;
    check_hs("rst_cnt_preempt", 1'b1, 1'b1);
    push(5'd20, 32'hCAFE0020);
    tick();
    idle();
    tick();
    check_drained("rst_mid_drain");
  endtask

  initial begin
    idle();
    rst       = 1'b1;
    rd_a_addr = '0;
    rd_b_addr = '0;
    test_reset();
    test_ex_only();
    test_starvation();
    test_scoreboard();
    test_set_clear_conflict();
    test_r0();
    test_reset_mid();
    tick();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
